// File: rtl/alu_core.sv
// Registered single-issue integer ALU: one-cycle latency, result/zero/valid registered together.
// Optional carry/overflow/negative outputs are enabled by defining ALU_EXT_FLAGS_EN.
module alu_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_op,
`ifdef ALU_EXT_FLAGS_EN
    output logic             carry,
    output logic             overflow,
    output logic             negative,
`endif
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    logic signed [WIDTH-1:0] w_a_s;
    logic signed [WIDTH-1:0] w_b_s;
    logic        [WIDTH-1:0] w_sum;
    logic        [WIDTH-1:0] w_diff;
    logic        [SHW-1:0]   w_shamt;
    logic                    w_lt;
    logic        [WIDTH-1:0] w_res;

    logic                    r_vld_p1;
    logic        [WIDTH-1:0] r_result_p1;
    logic                    r_zero_p1;

    assign w_a_s   = $signed(a);
    assign w_b_s   = $signed(b);
    assign w_diff  = a - b;
    assign w_shamt = b[SHW-1:0];
    assign w_lt    = (w_a_s < w_b_s);

`ifdef ALU_EXT_FLAGS_EN
    logic w_add_co;
    logic w_carry;
    logic w_ovf;
    logic r_carry_p1;
    logic r_ovf_p1;
    logic r_neg_p1;

    assign {w_add_co, w_sum} = {1'b0, a} + {1'b0, b};

    // SUB carry is the inverted borrow, i.e. unsigned a >= b.
    always_comb begin
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (alu_op)
            OP_ADD: begin
                w_carry = w_add_co;
                w_ovf   = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                w_carry = (a >= b);
                w_ovf   = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
            end
            default: begin
                w_carry = 1'b0;
                w_ovf   = 1'b0;
            end
        endcase
    end
`else
    assign w_sum = a + b;
`endif

    always_comb begin
        w_res = '0;
        case (alu_op)
            OP_ADD:  w_res = w_sum;
            OP_SUB:  w_res = w_diff;
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_lt};
            OP_SLL:  w_res = a << w_shamt;
            OP_SRL:  w_res = a >> w_shamt;
            default: w_res = '0;
        endcase
    end

    // Stage p0 -> p1: register result and flags; idle cycles hold the last result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1    <= 1'b0;
            r_result_p1 <= '0;
            r_zero_p1   <= 1'b0;
`ifdef ALU_EXT_FLAGS_EN
            r_carry_p1  <= 1'b0;
            r_ovf_p1    <= 1'b0;
            r_neg_p1    <= 1'b0;
`endif
        end else begin
            r_vld_p1 <= in_valid;
            if (in_valid) begin
                r_result_p1 <= w_res;
                r_zero_p1   <= (w_res == '0);
`ifdef ALU_EXT_FLAGS_EN
                r_carry_p1  <= w_carry;
                r_ovf_p1    <= w_ovf;
                r_neg_p1    <= w_res[MSB];
`endif
            end
        end
    end

    assign out_valid = r_vld_p1;
    assign result    = r_result_p1;
    assign zero      = r_zero_p1;
`ifdef ALU_EXT_FLAGS_EN
    assign carry     = r_carry_p1;
    assign overflow  = r_ovf_p1;
    assign negative  = r_neg_p1;
`endif

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed scenarios plus randomized ops against an arithmetic model.
// Flag outputs are checked as well when ALU_EXT_FLAGS_EN is defined.
module tb_alu_core;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   alu_op;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
`ifdef ALU_EXT_FLAGS_EN
    logic         carry;
    logic         overflow;
    logic         negative;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .alu_op    (alu_op),
`ifdef ALU_EXT_FLAGS_EN
        .carry     (carry),
        .overflow  (overflow),
        .negative  (negative),
`endif
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero)
    );

    // Reference model: plain integer arithmetic on 64-bit values.
    function automatic logic [W-1:0] ref_res(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        longint ux = longint'(x);
        longint uy = longint'(y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint r;
        case (op)
            3'd0: r = (ux + uy) % (64'd1 << W);
            3'd1: r = (ux - uy + (64'd1 << W)) % (64'd1 << W);
            3'd2: r = ux & uy;
            3'd3: r = ux | uy;
            3'd4: r = ux ^ uy;
            3'd5: r = (sx < sy) ? 1 : 0;
            3'd6: r = (ux * (64'd1 << (uy % W))) % (64'd1 << W);
            default: r = ux / (64'd1 << (uy % W));
        endcase
        return W'(r);
    endfunction

    function automatic logic ref_carry(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        if (op == 3'd0) return (longint'(x) + longint'(y)) >= (64'd1 << W);
        if (op == 3'd1) return longint'(x) >= longint'(y);
        return 1'b0;
    endfunction

    function automatic logic ref_ovf(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint lo = -(64'sd1 <<< (W - 1));
        longint hi = (64'sd1 <<< (W - 1)) - 1;
        longint s;
        if (op == 3'd0) s = sx + sy;
        else if (op == 3'd1) s = sx - sy;
        else return 1'b0;
        return (s < lo) || (s > hi);
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; a = 32'd7; b = 32'd3; alu_op = 3'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0) begin
                bad++;
                $display("FAIL reset[%0d] got v=%b r=%h z=%b want v=0 r=0 z=0", i, out_valid, result, zero);
            end
`ifdef ALU_EXT_FLAGS_EN
            total++;
            if ({carry, overflow, negative} !== 3'b000) begin
                bad++;
                $display("FAIL reset_flags[%0d] got %b want 000", i, {carry, overflow, negative});
            end
`endif
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || result !== 32'd10 || zero !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got v=%b r=%h z=%b want v=1 r=a z=0", out_valid, result, zero);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [2:0]   ops[4] = '{3'd0, 3'd0, 3'd1, 3'd1};
        logic [W-1:0] av[4]  = '{32'd10, 32'd100, 32'd10, 32'd100};
        logic [W-1:0] bv[4]  = '{32'd5, 32'd50, 32'd5, 32'd25};
        logic [W-1:0] ev[4]  = '{32'd15, 32'd150, 32'd5, 32'd75};
        int nvalid = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; alu_op = ops[i]; a = av[i]; b = bv[i];
            @(negedge clk);
            if (out_valid === 1'b1) nvalid++;
            total++;
            if (out_valid !== 1'b1 || result !== ev[i] || zero !== 1'b0) begin
                bad++;
                $display("FAIL addsub[%0d] got v=%b r=%0d z=%b want v=1 r=%0d z=0", i, out_valid, result, zero, ev[i]);
            end
        end
        in_valid = 1'b0;
        total++;
        if (nvalid != 4) begin
            bad++;
            $display("FAIL b2b_valid_run got %0d want 4", nvalid);
        end
        @(negedge clk);
    endtask

    task automatic test_logic();
        logic [2:0]   ops[3] = '{3'd2, 3'd3, 3'd4};
        logic [W-1:0] av[3]  = '{32'hF0F0, 32'hF000, 32'hFFFF};
        logic [W-1:0] bv[3]  = '{32'h0FF0, 32'h0F00, 32'hFFFF};
        logic [W-1:0] ev[3]  = '{32'h00F0, 32'hFF00, 32'h0};
        logic         ez[3]  = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; alu_op = ops[i]; a = av[i]; b = bv[i];
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || result !== ev[i] || zero !== ez[i]) begin
                bad++;
                $display("FAIL logic[%0d] got v=%b r=%h z=%b want v=1 r=%h z=%b", i, out_valid, result, zero, ev[i], ez[i]);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_edge_arith();
        logic [2:0]   ops[3] = '{3'd1, 3'd0, 3'd0};
        logic [W-1:0] av[3]  = '{32'd5, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        logic [W-1:0] bv[3]  = '{32'd5, 32'd1, 32'd1};
        logic [W-1:0] ev[3]  = '{32'd0, 32'd0, 32'h8000_0000};
        logic         ez[3]  = '{1'b1, 1'b1, 1'b0};
`ifdef ALU_EXT_FLAGS_EN
        logic [2:0]   ef[3]  = '{3'b100, 3'b100, 3'b011};
`endif
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; alu_op = ops[i]; a = av[i]; b = bv[i];
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || result !== ev[i] || zero !== ez[i]) begin
                bad++;
                $display("FAIL edge[%0d] got v=%b r=%h z=%b want v=1 r=%h z=%b", i, out_valid, result, zero, ev[i], ez[i]);
            end
`ifdef ALU_EXT_FLAGS_EN
            total++;
            if ({carry, overflow, negative} !== ef[i]) begin
                bad++;
                $display("FAIL edge_flags[%0d] got cvn=%b want %b", i, {carry, overflow, negative}, ef[i]);
            end
`endif
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_slt_shift();
        logic [2:0]   ops[4] = '{3'd5, 3'd5, 3'd6, 3'd7};
        logic [W-1:0] av[4]  = '{32'hFFFF_FFFF, 32'd1, 32'd1, 32'h8000_0000};
        logic [W-1:0] bv[4]  = '{32'd1, 32'hFFFF_FFFF, 32'd36, 32'd31};
        logic [W-1:0] ev[4]  = '{32'd1, 32'd0, 32'h10, 32'd1};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; alu_op = ops[i]; a = av[i]; b = bv[i];
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || result !== ev[i] || zero !== (ev[i] == 0)) begin
                bad++;
                $display("FAIL sltshift[%0d] got v=%b r=%h z=%b want v=1 r=%h", i, out_valid, result, zero, ev[i]);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_hold_reset();
        in_valid = 1'b1; alu_op = 3'd0; a = 32'd3; b = 32'd4;
        @(negedge clk);
        in_valid = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; alu_op = 3'd4;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || result !== 32'd7 || zero !== 1'b0) begin
            bad++;
            $display("FAIL hold got v=%b r=%h z=%b want v=0 r=7 z=0", out_valid, result, zero);
        end
        rst = 1'b1; in_valid = 1'b1; alu_op = 3'd0; a = 32'd1; b = 32'd1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0) begin
            bad++;
            $display("FAIL rst_midstream got v=%b r=%h z=%b want v=0 r=0 z=0", out_valid, result, zero);
        end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || result !== 32'd0) begin
            bad++;
            $display("FAIL rst_discard got v=%b r=%h want v=0 r=0", out_valid, result);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] pool[6] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'd31};
        logic [W-1:0] exp_r = result;
        logic         exp_z = zero;
        logic         exp_v;
`ifdef ALU_EXT_FLAGS_EN
        logic [2:0]   exp_f = {carry, overflow, negative};
`endif
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 39) == 0);
            in_valid = ($urandom_range(0, 4) != 0);
            alu_op   = 3'($urandom_range(0, 7));
            a        = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
            b        = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
            if (rst) begin
                exp_v = 1'b0; exp_r = '0; exp_z = 1'b0;
`ifdef ALU_EXT_FLAGS_EN
                exp_f = 3'b000;
`endif
            end else begin
                exp_v = in_valid;
                if (in_valid) begin
                    exp_r = ref_res(alu_op, a, b);
                    exp_z = (exp_r == 0);
`ifdef ALU_EXT_FLAGS_EN
                    exp_f = {ref_carry(alu_op, a, b), ref_ovf(alu_op, a, b), exp_r[W-1]};
`endif
                end
            end
            @(negedge clk);
            total++;
            if (out_valid !== exp_v || result !== exp_r || zero !== exp_z) begin
                bad++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h got v=%b r=%h z=%b want v=%b r=%h z=%b",
                         i, alu_op, a, b, out_valid, result, zero, exp_v, exp_r, exp_z);
            end
`ifdef ALU_EXT_FLAGS_EN
            total++;
            if ({carry, overflow, negative} !== exp_f) begin
                bad++;
                $display("FAIL random_flags[%0d] op=%0d a=%h b=%h got %b want %b",
                         i, alu_op, a, b, {carry, overflow, negative}, exp_f);
            end
`endif
        end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_logic();
        test_edge_arith();
        test_slt_shift();
        test_hold_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
Registered 32-bit integer ALU for the datapath execute stage. It accepts two operands and a 3-bit opcode with a valid strobe. One clock later it produces a registered result, a zero flag and a matching valid strobe. It is purely single-issue: no stalls, no internal queueing.

Parameters:
WIDTH, 32, operand/result width in bits (must be >= 2 and a power of two; shift amount uses log2(WIDTH) bits).

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset; sampled on rising edge of clk
in_valid  input  1  operands/opcode valid this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
alu_op  input  3  operation select
out_valid  output  1  result/zero valid (registered)
result  output  WIDTH  registered operation result
zero  output  1  registered; 1 when result == 0

Behaviour:
- Reset: when rst=1 at a clk edge, result=0, zero=0 and out_valid=0 (and carry/overflow/negative=0 if the optional feature is enabled). Reset has priority over in_valid in the same cycle.
- Latency: exactly 1 cycle. Inputs are sampled at edge N with in_valid=1; result, zero and out_valid=1 are visible after edge N.
- Throughput: 1 op/cycle, back-to-back in_valid accepted; no backpressure.
- in_valid=0 at an edge: out_valid goes to 0, and result/zero hold their previous values.
- Opcodes (combinational compute, registered output):
  - 000 ADD: a+b, modulo 2^WIDTH, wraps silently.
  - 001 SUB: a-b, modulo 2^WIDTH (two's complement; 0-1 = all ones).
  - 010 AND: a & b.
  - 011 OR: a | b.
  - 100 XOR: a ^ b.
  - 101 SLT: result = 1 if signed(a) < signed(b), else 0; upper bits zero.
  - 110 SLL: a << b[log2(WIDTH)-1:0]; upper bits of b are ignored.
  - 111 SRL: logical a >> b[log2(WIDTH)-1:0], zero fill.
- zero is computed from the new result in the same edge it is registered; it is never one cycle stale.
- No X propagation: every opcode value is defined. Inputs are don't-care when in_valid=0.
- Purely synchronous design; no latches, no asynchronous paths from inputs to outputs.

Optional Feature:
ALU_EXT_FLAGS_EN.
- Defined: adds three registered outputs, updated with the same timing and reset rules as zero:
  - carry (1 bit): ADD carry-out of the MSB; SUB not-borrow, i.e. 1 when a >= b unsigned.
  - overflow (1 bit): signed overflow for ADD/SUB.
  - negative (1 bit): result[WIDTH-1].
  - For logic, shift and SLT ops, carry=0 and overflow=0; negative still tracks the MSB of result.
- Undefined: these ports and their logic do not exist. All other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, a=7, b=3, op=000 -> result=0, zero=0, out_valid=0. After release, the next accepted op updates the outputs normally.
- ADD/SUB: 10+5 -> 15, 100+50 -> 150, 10-5 -> 5, 100-25 -> 75, each one cycle after acceptance with zero=0. Back-to-back issue -> four consecutive out_valid=1 cycles, in order.
- Logic: 0xF0F0 AND 0x0FF0 -> 0x00F0; 0xF000 OR 0x0F00 -> 0xFF00; 0xFFFF XOR 0xFFFF -> 0 with zero=1.
- Edge arithmetic: 5-5 -> 0, zero=1; 0xFFFFFFFF+1 -> 0, zero=1 (with ALU_EXT_FLAGS_EN: carry=1, overflow=0); 0x7FFFFFFF+1 -> 0x80000000 (overflow=1, negative=1).
- SLT/shifts: SLT(0xFFFFFFFF, 1) -> 1; SLT(1, 0xFFFFFFFF) -> 0; SLL(1, 36) -> 0x10; SRL(0x80000000, 31) -> 1.
- Hold/reset mid-stream: issue op, then in_valid=0 -> out_valid drops while result holds its value. Assert rst in the same cycle as in_valid=1 -> outputs return to reset values and the op is discarded.
